// File: rtl/i2c_sram_master.sv
// i2c_sram_master -- I2C master for a 16-bit-word SRAM-style slave.
//
// One command moves one 16-bit word:
//   START, {dev[6:0], rw}, ack, mem[7:0], ack, data hi, ack, data lo, ack/nack, STOP
// Every bit takes 4 phases of CLK_DIV clocks:
//   P0 SCL low (SDA update), P1 SCL high, P2 SCL high (sample), P3 SCL low.
//
// Optional feature (build macro I2C_SRAM_MASTER_ACK_CHECK_EN):
//   defined   - a slave NACK sets ack_error and cuts the frame short to STOP
//   undefined - slave ACK slots are ignored, ack_error is tied to 0
//
// Ports:
//   clk, reset                  clock, asynchronous active-high reset
//   cmd_valid/cmd_rw/cmd_*      command, accepted only while idle
//   busy, done                  in-flight flag, one-cycle end-of-frame pulse
//   rdata                       read word, valid from done to the next accept
//   ack_error                   slave NACK seen during the last frame
//   scl, sda_o, sda_oe, sda_in  I2C pins (SCL push-pull, SDA open-drain style)
module i2c_sram_master #(
  parameter int CLK_DIV = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  input  logic        cmd_rw,
  input  logic [6:0]  cmd_dev_addr,
  input  logic [7:0]  cmd_mem_addr,
  input  logic [15:0] cmd_wdata,
  output logic        busy,
  output logic        done,
  output logic [15:0] rdata,
  output logic        ack_error,
  output logic        scl,
  output logic        sda_o,
  output logic        sda_oe,
  input  logic        sda_in
);

  typedef enum logic [3:0] {
    IDLE, START, ADDR, ADDR_ACK, MADDR, MADDR_ACK,
    WR_HI, WR_HI_ACK, WR_LO, WR_LO_ACK,
    RD_HI, RD_HI_ACK, RD_LO, RD_LO_NACK, STOP
  } state_t;

  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

  state_t      state, state_n;
  logic [7:0]  div_cnt;
  logic [1:0]  phase;
  logic [2:0]  bit_cnt;
  logic [6:0]  dev_q;
  logic        rw_q;
  logic [7:0]  mem_q;
  logic [15:0] wdata_q;

  logic        accept, tick, bit_end, sample, byte_last, is_byte, bit_scl;
  logic        nack_stop;
  logic [7:0]  tx_byte;

  assign tick      = (div_cnt == DIV_LAST);
  assign sample    = tick && (phase == 2'd2);
  assign bit_end   = tick && (phase == 2'd3);
  assign byte_last = (bit_cnt == 3'd7);
  assign bit_scl   = phase[0] ^ phase[1];  // high in P1 and P2
  assign busy      = (state != IDLE);
  assign is_byte   = (state == ADDR) || (state == MADDR) || (state == WR_HI) ||
                     (state == WR_LO) || (state == RD_HI) || (state == RD_LO);

`ifdef I2C_SRAM_MASTER_ACK_CHECK_EN
  logic ack_pend, ack_err_q, slave_ack_slot;
  assign slave_ack_slot = (state == ADDR_ACK) || (state == MADDR_ACK) ||
                          (state == WR_HI_ACK) || (state == WR_LO_ACK);
  assign nack_stop = ack_pend;
  assign ack_error = ack_err_q;

  // A NACK is remembered from its P2 sample until the frame ends, where it
  // is published together with done.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ack_pend  <= 1'b0;
      ack_err_q <= 1'b0;
    end else if (accept) begin
      ack_pend  <= 1'b0;
      ack_err_q <= 1'b0;
    end else begin
      if (sample && slave_ack_slot && sda_in) ack_pend <= 1'b1;
      if (state == STOP && bit_end)           ack_err_q <= ack_pend;
    end
  end
`else
  assign nack_stop = 1'b0;
  assign ack_error = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  // Next state and pin decode. Pins decode only from registered state.
  always_comb begin
    state_n = state;
    accept  = 1'b0;
    scl     = 1'b1;
    sda_o   = 1'b1;
    sda_oe  = 1'b0;
    case (state)
      ADDR:    tx_byte = {dev_q, rw_q};
      MADDR:   tx_byte = mem_q;
      WR_HI:   tx_byte = wdata_q[15:8];
      default: tx_byte = wdata_q[7:0];
    endcase

    case (state)
      IDLE:       if (cmd_valid) begin state_n = START; accept = 1'b1; end
      START:      if (bit_end) state_n = ADDR;
      ADDR:       if (bit_end && byte_last) state_n = ADDR_ACK;
      ADDR_ACK:   if (bit_end) state_n = nack_stop ? STOP : MADDR;
      MADDR:      if (bit_end && byte_last) state_n = MADDR_ACK;
      MADDR_ACK:  if (bit_end) state_n = nack_stop ? STOP : (rw_q ? RD_HI : WR_HI);
      WR_HI:      if (bit_end && byte_last) state_n = WR_HI_ACK;
      WR_HI_ACK:  if (bit_end) state_n = nack_stop ? STOP : WR_LO;
      WR_LO:      if (bit_end && byte_last) state_n = WR_LO_ACK;
      WR_LO_ACK:  if (bit_end) state_n = STOP;
      RD_HI:      if (bit_end && byte_last) state_n = RD_HI_ACK;
      RD_HI_ACK:  if (bit_end) state_n = RD_LO;
      RD_LO:      if (bit_end && byte_last) state_n = RD_LO_NACK;
      RD_LO_NACK: if (bit_end) state_n = STOP;
      STOP:       if (bit_end) state_n = IDLE;
      default:    state_n = IDLE;
    endcase

    case (state)
      START: begin                  // SDA drops in P1 with SCL high, SCL drops in P3
        scl    = (phase != 2'd3);
        sda_oe = 1'b1;
        sda_o  = (phase == 2'd0);
      end
      STOP: begin                   // SCL rises in P1, SDA rises in P2
        scl    = (phase != 2'd0);
        sda_oe = 1'b1;
        sda_o  = phase[1];
      end
      ADDR, MADDR, WR_HI, WR_LO: begin
        scl    = bit_scl;
        sda_oe = 1'b1;
        sda_o  = tx_byte[~bit_cnt]; // MSB first
      end
      RD_HI_ACK: begin
        scl    = bit_scl;
        sda_oe = 1'b1;
        sda_o  = 1'b0;
      end
      RD_LO_NACK: begin
        scl    = bit_scl;
        sda_oe = 1'b1;
        sda_o  = 1'b1;
      end
      IDLE: ;
      default: scl = bit_scl;       // slave-driven slots: SDA released
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_cnt <= '0;
      phase   <= '0;
      bit_cnt <= '0;
      dev_q   <= '0;
      rw_q    <= 1'b0;
      mem_q   <= '0;
      wdata_q <= '0;
      rdata   <= '0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      if (accept) begin
        dev_q   <= cmd_dev_addr;
        rw_q    <= cmd_rw;
        mem_q   <= cmd_mem_addr;
        wdata_q <= cmd_wdata;
        div_cnt <= '0;
        phase   <= '0;
        bit_cnt <= '0;
      end else if (state != IDLE) begin
        div_cnt <= tick ? 8'd0 : div_cnt + 8'd1;
        if (tick) phase <= phase + 2'd1;
        // 3-bit counter wraps to 0 on the last bit of each byte
        if (bit_end && is_byte) bit_cnt <= bit_cnt + 3'd1;
        if (sample && state == RD_HI) rdata[15:8] <= {rdata[14:8], sda_in};
        if (sample && state == RD_LO) rdata[7:0]  <= {rdata[6:0], sda_in};
        if (state == STOP && bit_end) done <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_i2c_sram_master.sv
module tb_i2c_sram_master;
  localparam int CLK_DIV  = 4;
  localparam int FULL_CYC = 38 * 4 * CLK_DIV;
  localparam int NACK_CYC = 11 * 4 * CLK_DIV;
  localparam logic [6:0] SLAVE_ADDR = 7'h3C;

  logic        clk = 1'b0, reset = 1'b1;
  logic        cmd_valid = 1'b0, cmd_rw = 1'b0;
  logic [6:0]  cmd_dev_addr = '0;
  logic [7:0]  cmd_mem_addr = '0;
  logic [15:0] cmd_wdata = '0;
  logic        busy, done, ack_error, scl, sda_o, sda_oe, sda_line;
  logic [15:0] rdata;
  logic        sl_drive0 = 1'b0;

  // Open-drain bus with pull-up; the slave model can only pull low.
  assign sda_line = (sda_oe ? sda_o : 1'b1) & ~sl_drive0;

  always #5 clk = ~clk;

  i2c_sram_master #(.CLK_DIV(CLK_DIV)) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_rw(cmd_rw),
    .cmd_dev_addr(cmd_dev_addr), .cmd_mem_addr(cmd_mem_addr), .cmd_wdata(cmd_wdata),
    .busy(busy), .done(done), .rdata(rdata), .ack_error(ack_error),
    .scl(scl), .sda_o(sda_o), .sda_oe(sda_oe), .sda_in(sda_line)
  );

  int n_vec = 0, n_err = 0;
  logic [8:0] sb[$];  // expected {byte seen on SDA, ack/nack bit}

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic exp_byte(input logic [7:0] b, input logic a);
    sb.push_back({b, a});
  endtask

  // ---------------- slave model / bus monitor ----------------
  logic        prev_scl = 1'b1, prev_sda = 1'b1, s;
  int          bitn = 0, byten = 0;
  logic [7:0]  sh = '0, ptr = '0, hi = '0, txb = '0;
  logic        addressed = 1'b0, rd_mode = 1'b0, tx_mode = 1'b0;
  logic [15:0] mem [256];
  logic [8:0]  item;

  always @(negedge clk) begin
    s = sda_line;
    if (scl && prev_scl && prev_sda && !s) begin          // START
      bitn = 0; byten = 0; tx_mode = 1'b0; addressed = 1'b0; sl_drive0 = 1'b0;
    end else if (scl && prev_scl && !prev_sda && s) begin // STOP
      bitn = 0; tx_mode = 1'b0; sl_drive0 = 1'b0;
    end else if (scl && !prev_scl) begin                  // SCL rise: sample
      if (bitn < 8) sh = {sh[6:0], s};
      else begin
        n_vec++;
        assert (sb.size() != 0) else begin
          n_err++;
          $error("FAIL sb_extra: observed 0x%0h, expected no byte", {sh, s});
        end
        if (sb.size() != 0) begin
          item = sb.pop_front();
          chk("sda_byte_ack", 32'({sh, s}), 32'(item));
        end
      end
      bitn++;
    end else if (!scl && prev_scl) begin                  // SCL fall: drive
      if (bitn == 8) begin
        if (tx_mode) sl_drive0 = 1'b0;
        else begin
          case (byten)
            0: begin addressed = (sh[7:1] == SLAVE_ADDR); rd_mode = sh[0]; end
            1: ptr = sh;
            2: hi = sh;
            3: if (addressed && !rd_mode) mem[ptr] = {hi, sh};
            default: ;
          endcase
          sl_drive0 = addressed;
        end
      end else if (bitn == 9) begin
        bitn = 0; byten++;
        tx_mode = addressed && rd_mode && (byten == 2 || byten == 3);
        if (tx_mode) begin
          txb = (byten == 2) ? mem[ptr][15:8] : mem[ptr][7:0];
          sl_drive0 = ~txb[7];
        end else sl_drive0 = 1'b0;
      end else if (tx_mode && bitn >= 1 && bitn <= 7) begin
        sl_drive0 = ~txb[3'(7 - bitn)];
      end
    end
    prev_scl = scl;
    prev_sda = s;
  end

  // Call at a negedge. Launches one command and waits (bounded) for done.
  // With poke set, a conflicting command is offered mid-frame.
  task automatic run_cmd(input logic rw, input logic [6:0] dev, input logic [7:0] ma,
                         input logic [15:0] wd, input int exp_cyc, input bit poke,
                         input string tag);
    int cyc;
    bit got;
    cmd_valid = 1'b1; cmd_rw = rw; cmd_dev_addr = dev; cmd_mem_addr = ma; cmd_wdata = wd;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    chk({tag, "_busy_on"}, 32'(busy), 32'd1);
    cyc = 0; got = 0;
    while (!got && cyc < exp_cyc + 100) begin
      @(posedge clk); cyc++; #1;
      if (done) got = 1;
      if (poke && cyc == 100) begin
        cmd_valid = 1'b1; cmd_rw = 1'b1; cmd_dev_addr = SLAVE_ADDR;
        cmd_mem_addr = 8'h10; cmd_wdata = 16'hFFFF;
      end
      if (poke && cyc == 103) cmd_valid = 1'b0;
    end
    chk({tag, "_latency"}, 32'(cyc), 32'(exp_cyc));
    chk({tag, "_busy_off"}, 32'(busy), 32'd0);
    @(posedge clk); #1;
    chk({tag, "_done_pulse"}, 32'(done), 32'd0);
    chk({tag, "_sb_drained"}, 32'(sb.size()), 32'd0);
    @(negedge clk);
  endtask

  initial begin
    bit saw_done;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_rdata", 32'(rdata), 32'd0);
    chk("rst_ack_error", 32'(ack_error), 32'd0);
    chk("rst_scl", 32'(scl), 32'd1);
    chk("rst_sda_o", 32'(sda_o), 32'd1);
    chk("rst_sda_oe", 32'(sda_oe), 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // write 0x5093 to 0x7C, accepted on the first edge after reset release
    exp_byte(8'h78, 1'b0); exp_byte(8'h7C, 1'b0); exp_byte(8'h50, 1'b0); exp_byte(8'h93, 1'b0);
    run_cmd(1'b0, 7'h3C, 8'h7C, 16'h5093, FULL_CYC, 1'b0, "wr1");
    chk("wr1_ack_error", 32'(ack_error), 32'd0);

    // read it back: master ACKs high byte, NACKs low byte
    exp_byte(8'h79, 1'b0); exp_byte(8'h7C, 1'b0); exp_byte(8'h50, 1'b0); exp_byte(8'h93, 1'b1);
    run_cmd(1'b1, 7'h3C, 8'h7C, 16'h0000, FULL_CYC, 1'b0, "rd1");
    chk("rd1_rdata", 32'(rdata), 32'h5093);

    // 1234 round trip
    exp_byte(8'h78, 1'b0); exp_byte(8'h10, 1'b0); exp_byte(8'h04, 1'b0); exp_byte(8'hD2, 1'b0);
    run_cmd(1'b0, 7'h3C, 8'h10, 16'h04D2, FULL_CYC, 1'b0, "wr2");
    exp_byte(8'h79, 1'b0); exp_byte(8'h10, 1'b0); exp_byte(8'h04, 1'b0); exp_byte(8'hD2, 1'b1);
    run_cmd(1'b1, 7'h3C, 8'h10, 16'h0000, FULL_CYC, 1'b0, "rd2");
    chk("rd2_rdata", 32'(rdata), 32'h04D2);

    // nobody answers at 0x12
`ifdef I2C_SRAM_MASTER_ACK_CHECK_EN
    exp_byte(8'h24, 1'b1);
    run_cmd(1'b0, 7'h12, 8'h55, 16'hAAAA, NACK_CYC, 1'b0, "nack");
    chk("nack_ack_error", 32'(ack_error), 32'd1);
`else
    exp_byte(8'h24, 1'b1); exp_byte(8'h55, 1'b1); exp_byte(8'hAA, 1'b1); exp_byte(8'hAA, 1'b1);
    run_cmd(1'b0, 7'h12, 8'h55, 16'hAAAA, FULL_CYC, 1'b0, "nack");
    chk("nack_ack_error", 32'(ack_error), 32'd0);
`endif
    chk("nack_rdata_hold", 32'(rdata), 32'h04D2);

    // read 0x7C while a conflicting read of 0x10 is offered mid-frame
    exp_byte(8'h79, 1'b0); exp_byte(8'h7C, 1'b0); exp_byte(8'h50, 1'b0); exp_byte(8'h93, 1'b1);
    run_cmd(1'b1, 7'h3C, 8'h7C, 16'h0000, FULL_CYC, 1'b1, "poke");
    chk("poke_rdata", 32'(rdata), 32'h5093);
    chk("poke_ack_error_cleared", 32'(ack_error), 32'd0);
    repeat (10) @(posedge clk);
    #1;
    chk("poke_not_queued", 32'(busy), 32'd0);
    @(negedge clk);

    // reset during WR_HI bit 3 (cycle 354 = bit 22, phase P0)
    exp_byte(8'h78, 1'b0); exp_byte(8'h20, 1'b0);
    cmd_valid = 1'b1; cmd_rw = 1'b0; cmd_dev_addr = 7'h3C; cmd_mem_addr = 8'h20; cmd_wdata = 16'hBEEF;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    repeat (354) @(posedge clk);
    #2;
    chk("mid_scl_low", 32'(scl), 32'd0);
    chk("mid_sda_oe", 32'(sda_oe), 32'd1);
    #1 reset = 1'b1;
    #1;
    chk("arst_scl", 32'(scl), 32'd1);
    chk("arst_sda_oe", 32'(sda_oe), 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_rdata", 32'(rdata), 32'd0);
    saw_done = 0;
    repeat (3) @(posedge clk) begin #1; if (done) saw_done = 1; end
    @(negedge clk);
    reset = 1'b0;
    repeat (40) @(posedge clk) begin #1; if (done) saw_done = 1; end
    chk("arst_no_done", 32'(saw_done), 32'd0);
    chk("arst_sb_abandoned", 32'(sb.size()), 32'd0);
    @(negedge clk);

    exp_byte(8'h78, 1'b0); exp_byte(8'h20, 1'b0); exp_byte(8'hBE, 1'b0); exp_byte(8'hEF, 1'b0);
    run_cmd(1'b0, 7'h3C, 8'h20, 16'hBEEF, FULL_CYC, 1'b0, "wr3");
    exp_byte(8'h79, 1'b0); exp_byte(8'h20, 1'b0); exp_byte(8'hBE, 1'b0); exp_byte(8'hEF, 1'b1);
    run_cmd(1'b1, 7'h3C, 8'h20, 16'h0000, FULL_CYC, 1'b0, "rd3");
    chk("rd3_rdata", 32'(rdata), 32'hBEEF);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/i2c_sram_master.md
I2C_SRAM_MASTER -- requirements
Module: i2c_sram_master

Interface
REQ-001 Parameter CLK_DIV, default 4: clk cycles per SCL quarter-bit phase; legal range 2..255.
REQ-002 clk  input  1  sole clock; all state changes on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 cmd_valid  input  1  request a transaction; accepted only in IDLE.
REQ-005 cmd_rw  input  1  selects the mode bit: 0 = write, 1 = read.
REQ-006 cmd_dev_addr  input  7  target device address, sent MSB first.
REQ-007 cmd_mem_addr  input  8  SRAM word address, sent MSB first.
REQ-008 cmd_wdata  input  16  write data, sent high byte first.
REQ-009 busy  output  1  high from acceptance until done.
REQ-010 done  output  1  one-cycle pulse at transaction end.
REQ-011 rdata  output  16  read data, valid from done until the next acceptance.
REQ-012 ack_error  output  1  set with done when the slave NACKed; cleared on the next acceptance.
REQ-013 scl  output  1  I2C clock, push-pull.
REQ-014 sda_o  output  1  SDA drive value.
REQ-015 sda_oe  output  1  SDA drive enable; SDA is released when low.
REQ-016 sda_in  input  1  sampled SDA line.

Function
REQ-017 Bit time: 4 phases of CLK_DIV cycles (P0 SCL low/SDA update, P1 SCL rise, P2 SCL high/sample, P3 SCL fall).
REQ-018 In IDLE with cmd_valid=1, latch all cmd_* fields, set busy, clear ack_error, and enter START.
REQ-019 START: SDA falls while SCL is high, then SCL falls; one bit time.
REQ-020 Frame order, identical for both modes: START, 7 device bits, mode bit, slave ACK, 8 memory-address bits, slave ACK, then the data phase, then STOP.
REQ-021 Write data phase: data[15:8], slave ACK, data[7:0], slave ACK, all master-driven except the ACK slots.
REQ-022 Read data phase: sda_oe=0 for 8 bits into rdata[15:8], master ACK (drive 0), 8 bits into rdata[7:0], master NACK (drive 1).
REQ-023 Slave ACK slots: sda_oe=0; sample sda_in in P2; sda_in=1 is a NACK.
REQ-024 STOP: SDA low, SCL rises, then SDA rises; one bit time.
REQ-025 After STOP, pulse done, clear busy, and return to IDLE.
REQ-026 States: IDLE, START, ADDR, ADDR_ACK, MADDR, MADDR_ACK, WR_HI, WR_HI_ACK, WR_LO, WR_LO_ACK, RD_HI, RD_HI_ACK, RD_LO, RD_LO_NACK, STOP.
REQ-027 Latency without NACK: done asserts exactly 38*4*CLK_DIV cycles after the acceptance edge (608 cycles at CLK_DIV=4).
REQ-028 cmd_valid while busy is ignored; it is not queued.
REQ-029 cmd_* changes after acceptance do not affect the frame in flight.
REQ-030 A 3-bit bit counter and a phase counter wrap to 0 at each byte/bit boundary; no other arithmetic.
REQ-031 rdata updates only with sampled read bits and holds otherwise.
REQ-032 Idle bus: scl=1, sda_oe=0.

Reset
REQ-033 On reset assertion, independent of clk: state=IDLE, busy=0, done=0, rdata=0, ack_error=0, scl=1, sda_o=1, sda_oe=0, counters=0.
REQ-034 Reset mid-transaction abandons the frame immediately, with no STOP and no done pulse.
REQ-035 The first acceptance is possible on the first clk edge after reset deasserts.

Configuration
REQ-036 Macro I2C_SRAM_MASTER_ACK_CHECK_EN is defined: a NACK at any slave ACK slot sets ack_error and jumps directly to STOP, skipping the remaining bytes.
REQ-037 Macro I2C_SRAM_MASTER_ACK_CHECK_EN is undefined: slave ACK slots are not evaluated, the full frame always completes, and ack_error is tied to 0.

Verification
REQ-038 Write: dev 0x3C, mem 0x7C, data 0x5093, slave model ACKs -> SDA bits 0111100_0 / 01111100 / 01010000 / 10010011 are observed, done at cycle 608, ack_error=0.
REQ-039 Read: dev 0x3C, mem 0x7C after REQ-038 -> rdata=0x5093; master ACK after the high byte and NACK after the low byte.
REQ-040 Write 0x04D2 (1234), then read back -> rdata=0x04D2.
REQ-041 Dev 0x12 with no slave model (SDA pulled high) and ACK_CHECK_EN defined -> STOP follows ADDR_ACK, ack_error=1, done at 11*4*CLK_DIV cycles.
REQ-042 Reset asserted during WR_HI bit 3 -> scl=1, sda_oe=0, busy=0 within the same cycle; no done pulse; the next command completes normally.
REQ-043 cmd_valid pulsed while busy with different fields -> ignored; the in-flight frame and rdata are unchanged.
